// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Data is double-buffered: a load goes into a pending register, which moves
// into the displayed shadow register only at a frame wrap (digit 3 -> 0), so
// the display never tears. The anode, cathode and decimal-point outputs are
// registered from the current digit index and shadow contents.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic        lz_suppress,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_val_q, shadow_val_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          lead_zero;
  logic          dark;

  // Slot timing, digit advance and double-buffer transfer.
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    wrap         = tick && (idx_q == 2'd3);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    // Old pending is committed first; a coincident load then refills pending.
    if (wrap && pend_valid_q) begin
      shadow_val_d = pend_val_q;
      shadow_dp_d  = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    frame_done_d = wrap;
    load_ack_d   = wrap && pend_valid_q;
  end

  // Digit selection, hex decode and blanking for the next output register.
  always_comb begin
    nibble = shadow_val_q[idx_q*4 +: 4];
    case (nibble)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      default: seg_dec = 7'b0001110;
    endcase
    // Digit 0 is never treated as a leading zero.
    case (idx_q)
      2'd1:    lead_zero = (shadow_val_q[15:4] == 12'h000);
      2'd2:    lead_zero = (shadow_val_q[15:8] == 8'h00);
      2'd3:    lead_zero = (shadow_val_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
    dark = blank_mask[idx_q] || (lz_suppress && lead_zero);
    an_d  = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = dark ? 7'b1111111 : seg_dec;
    dp_d  = dark ? 1'b1 : ~shadow_dp_q[idx_q];
  end

  // State and output registers; reset wins over load and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule
